hbridge_driver: RTL and testbench

- Consumes the 4-bit H-bridge command produced by the movement-decision blocks (forward/reverse/turn/stop codes).
- Drives the physical IN1..IN4 pins and the two PWM enable pins.
- Inserts a coast dead-time whenever a motor's polarity would reverse.
- Feeds the currently applied code back as the "present INs" for the decision blocks.

---
 rtl/hbridge_codes_pkg.sv | 38 +++
 rtl/pwm_gen.sv | 41 ++++
 rtl/hbridge_driver.sv | 115 +++++++++++
 tb/tb_hbridge_driver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbridge_codes_pkg.sv
// H-bridge command codes shared by the driver and the movement-decision blocks.
// Codes are {IN1,IN2,IN3,IN4}; motor A = IN1/IN2, motor B = IN3/IN4.
package hbridge_codes_pkg;

    localparam logic [3:0] COAST      = 4'b0000;
    localparam logic [3:0] BRAKE      = 4'b1111;
    localparam logic [3:0] FORWARD    = 4'b0110;
    localparam logic [3:0] REVERSE    = 4'b1001;
    localparam logic [3:0] TURN_RIGHT = 4'b0101;
    localparam logic [3:0] TURN_LEFT  = 4'b1010;

    localparam int unsigned DEAD_W = 28;

    typedef enum logic {
        RUN      = 1'b0,
        DEADTIME = 1'b1
    } hbState_e;

    // One motor pair flips between 10 and 01.
    function automatic logic pairReverses(input logic [1:0] applied, input logic [1:0] requested);
        return ((applied == 2'b10) && (requested == 2'b01)) ||
               ((applied == 2'b01) && (requested == 2'b10));
    endfunction

    // Either motor pair flips polarity.
    function automatic logic codeReverses(input logic [3:0] applied, input logic [3:0] requested);
        return pairReverses(applied[3:2], requested[3:2]) ||
               pairReverses(applied[1:0], requested[1:0]);
    endfunction

    function automatic logic isValidCode(input logic [3:0] code);
        case (code)
            COAST, BRAKE, FORWARD, REVERSE, TURN_RIGHT, TURN_LEFT: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: prescaler, 6-bit tick counter, period-aligned duty latch.
// Ports: clock, reset (sync, active-high), duty (0..63),
//        pwmOut_c (combinational tick < latched duty).
module pwm_gen #(
    parameter int unsigned PWM_PRESCALE = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] duty,
    output logic       pwmOut_c
);

    localparam int unsigned PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [PRE_W-1:0] prescale;
    logic [5:0]       tick;
    logic [5:0]       dutyQ;
    logic             preWrap;

    assign preWrap = (prescale == PRE_W'(PWM_PRESCALE - 1));

    // Duty is only picked up as the tick counter rolls over, so periods are never torn.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescale <= '0;
            tick     <= '0;
            dutyQ    <= '0;
        end else if (preWrap) begin
            prescale <= '0;
            tick     <= tick + 6'd1;
            if (tick == 6'd63) begin
                dutyQ <= duty;
            end
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    assign pwmOut_c = (tick < dutyQ);

endmodule

// File: rtl/hbridge_driver.sv
// H-bridge pin driver with coast dead-time on motor polarity reversal.
// Ports: clock, reset (sync, active-high), cmd_ins {IN1..IN4} request, duty (0..63),
//        hb_ins pin drive, ena/enb PWM enables, applied_ins (= hb_ins),
//        dead_busy (in dead-time), cmd_invalid (pulse on unknown code).
module hbridge_driver
    import hbridge_codes_pkg::*;
#(
    parameter logic [27:0] DEAD_TIME_CYCLES = 28'd5000000,
    parameter int unsigned PWM_PRESCALE     = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cmd_ins,
    input  logic [5:0] duty,
    output logic [3:0] hb_ins,
    output logic       ena,
    output logic       enb,
    output logic [3:0] applied_ins,
    output logic       dead_busy,
    output logic       cmd_invalid
);

    hbState_e          state;
    hbState_e          stateNext;
    logic [DEAD_W-1:0] deadCount;
    logic [DEAD_W-1:0] deadNext;
    logic [3:0]        insNext;
    logic [3:0]        decoded;
    logic              cmdValid;
    logic              driveEn;
    logic              pwmOut_c;

    pwm_gen #(
        .PWM_PRESCALE(PWM_PRESCALE)
    ) u_pwm (
        .clock    (clock),
        .reset    (reset),
        .duty     (duty),
        .pwmOut_c (pwmOut_c)
    );

    // State, pin drive and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            deadCount   <= '0;
            hb_ins      <= COAST;
            ena         <= 1'b0;
            enb         <= 1'b0;
            dead_busy   <= 1'b0;
            cmd_invalid <= 1'b0;
        end else begin
            state       <= stateNext;
            deadCount   <= deadNext;
            hb_ins      <= insNext;
            ena         <= driveEn;
            enb         <= driveEn;
            dead_busy   <= (stateNext == DEADTIME);
            cmd_invalid <= ~cmdValid;
        end
    end

    // Decode, next state and next pin drive.
    always_comb begin
        stateNext = state;
        deadNext  = deadCount;
        insNext   = hb_ins;
        cmdValid  = isValidCode(cmd_ins);
        decoded   = cmdValid ? cmd_ins : COAST;

        case (state)
            RUN: begin
                if (decoded != hb_ins) begin
                    // BRAKE/COAST never reverse a pair, so they always fall through to apply.
                    if (codeReverses(hb_ins, decoded)) begin
                        insNext   = COAST;
                        deadNext  = DEAD_TIME_CYCLES - 28'd1;
                        stateNext = DEADTIME;
                    end else begin
                        insNext = decoded;
                    end
                end
            end
            DEADTIME: begin
                insNext = COAST;
                if (cmd_ins == BRAKE) begin
                    insNext   = BRAKE;
                    deadNext  = '0;
                    stateNext = RUN;
                end else if (deadCount == '0) begin
                    // Applied code is COAST here, so no second reversal check is needed.
                    insNext   = decoded;
                    stateNext = RUN;
                end else begin
                    deadNext = deadCount - 28'd1;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase

        // Enable mux: brake holds both enables high, coast/dead-time holds them low.
        if ((stateNext == DEADTIME) || (insNext == COAST)) begin
            driveEn = 1'b0;
        end else if (insNext == BRAKE) begin
            driveEn = 1'b1;
        end else begin
            driveEn = pwmOut_c;
        end
    end

    assign applied_ins = hb_ins;

endmodule

// File: tb/tb_hbridge_driver.sv
// Self-checking bench for hbridge_driver (DEAD_TIME_CYCLES = 10, PWM_PRESCALE = 2).
module tb_hbridge_driver;

    localparam int DEAD = 10;
    localparam int PRE  = 2;

    logic       clock;
    logic       reset;
    logic [3:0] cmd_ins;
    logic [5:0] duty;
    logic [3:0] hb_ins;
    logic       ena;
    logic       enb;
    logic [3:0] applied_ins;
    logic       dead_busy;
    logic       cmd_invalid;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state (updated at each rising edge from the inputs alone).
    int         mN       = 0;
    int         mDutyQ   = 0;
    int         mDeadLeft = 0;
    logic [3:0] mApplied = 4'b0000;
    logic       mInvalid = 1'b0;
    logic       mEna     = 1'b0;
    logic       mBusy    = 1'b0;

    hbridge_driver #(
        .DEAD_TIME_CYCLES(28'd10),
        .PWM_PRESCALE    (PRE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_ins     (cmd_ins),
        .duty        (duty),
        .hb_ins      (hb_ins),
        .ena         (ena),
        .enb         (enb),
        .applied_ins (applied_ins),
        .dead_busy   (dead_busy),
        .cmd_invalid (cmd_invalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Motor direction of a pin pair: +1, -1, or 0 for coast/brake.
    function automatic int dirOf(input logic [1:0] p);
        if (p == 2'b10) return 1;
        if (p == 2'b01) return -1;
        return 0;
    endfunction

    function automatic logic isKnown(input logic [3:0] c);
        return (c == 4'b0000) || (c == 4'b1111) || (c == 4'b0110) ||
               (c == 4'b1001) || (c == 4'b0101) || (c == 4'b1010);
    endfunction

    // Behavioural model: edge count gives PWM phase; dead-time is "edges left until apply".
    task automatic modelEdge();
        logic       pwmPrev;
        logic [3:0] dec;
        logic       flip;
        if (reset) begin
            mN = 0; mDutyQ = 0; mDeadLeft = 0; mApplied = 4'b0000;
            mInvalid = 1'b0; mEna = 1'b0; mBusy = 1'b0;
        end else begin
            pwmPrev = (((mN / PRE) % 64) < mDutyQ);
            mN++;
            if ((mN % (64 * PRE)) == 0) mDutyQ = int'(duty);
            mInvalid = !isKnown(cmd_ins);
            dec = mInvalid ? 4'b0000 : cmd_ins;
            flip = (dirOf(mApplied[3:2]) * dirOf(dec[3:2]) < 0) ||
                   (dirOf(mApplied[1:0]) * dirOf(dec[1:0]) < 0);
            if (mDeadLeft > 0) begin
                if (cmd_ins == 4'b1111) begin
                    mApplied = 4'b1111; mDeadLeft = 0;
                end else begin
                    mDeadLeft--;
                    if (mDeadLeft == 0) mApplied = dec;
                end
            end else if (flip) begin
                mApplied = 4'b0000; mDeadLeft = DEAD;
            end else begin
                mApplied = dec;
            end
            mBusy = (mDeadLeft > 0);
            if (mBusy || mApplied == 4'b0000) mEna = 1'b0;
            else if (mApplied == 4'b1111)     mEna = 1'b1;
            else                              mEna = pwmPrev;
        end
    endtask

    // One clock: model follows the edge, outputs are observed on the falling edge.
    task automatic step();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_ins = 4'b0000; duty = 6'd0;
        step(); step();
        checkCount++; if (hb_ins !== 4'b0000) $display("FAIL reset_hb got=%b want=0000", hb_ins); else passCount++;
        checkCount++; if (applied_ins !== 4'b0000) $display("FAIL reset_applied got=%b want=0000", applied_ins); else passCount++;
        checkCount++; if ({ena, enb, dead_busy, cmd_invalid} !== 4'b0000)
            $display("FAIL reset_flags got=%b want=0000", {ena, enb, dead_busy, cmd_invalid}); else passCount++;
        reset = 1'b0;
    endtask

    task automatic test_forward();
        int highs = 0;
        int mHighs = 0;
        cmd_ins = 4'b0110; duty = 6'd32;
        step();
        checkCount++; if (hb_ins !== 4'b0110) $display("FAIL fwd_apply got=%b want=0110", hb_ins); else passCount++;
        checkCount++; if (dead_busy !== 1'b0) $display("FAIL fwd_busy got=%b want=0", dead_busy); else passCount++;
        for (int i = 0; i < 300; i++) begin
            step();
            highs += int'(ena);
            mHighs += int'(mEna);
            checkCount++; if (ena !== mEna || enb !== mEnb())
                $display("FAIL fwd_pwm cyc=%0d got ena=%b enb=%b want=%b", i, ena, enb, mEna); else passCount++;
        end
        checkCount++; if (highs !== mHighs || highs == 0)
            $display("FAIL fwd_high_count got=%0d want=%0d", highs, mHighs); else passCount++;
    endtask

    function automatic logic mEnb();
        return mEna;
    endfunction

    task automatic test_reversal();
        int coast = 0;
        cmd_ins = 4'b1001;
        for (int i = 0; i < 30; i++) begin
            step();
            if (hb_ins == 4'b0000 && dead_busy) coast++;
            else break;
        end
        checkCount++; if (coast !== DEAD) $display("FAIL rev_coast got=%0d want=%0d", coast, DEAD); else passCount++;
        checkCount++; if (hb_ins !== 4'b1001) $display("FAIL rev_apply got=%b want=1001", hb_ins); else passCount++;
        checkCount++; if (dead_busy !== 1'b0) $display("FAIL rev_busy_end got=%b want=0", dead_busy); else passCount++;
    endtask

    task automatic test_brake_abort();
        cmd_ins = 4'b0110;
        for (int i = 0; i < 4; i++) step();
        checkCount++; if (dead_busy !== 1'b1 || hb_ins !== 4'b0000)
            $display("FAIL abort_in_dead got busy=%b hb=%b want 1/0000", dead_busy, hb_ins); else passCount++;
        cmd_ins = 4'b1111;
        step();
        checkCount++; if (hb_ins !== 4'b1111) $display("FAIL abort_brake got=%b want=1111", hb_ins); else passCount++;
        checkCount++; if ({ena, enb, dead_busy} !== 3'b110)
            $display("FAIL abort_flags got=%b want=110", {ena, enb, dead_busy}); else passCount++;
    endtask

    task automatic test_turns();
        int coast = 0;
        cmd_ins = 4'b0110;
        step();
        checkCount++; if (hb_ins !== 4'b0110) $display("FAIL turn_fwd got=%b want=0110", hb_ins); else passCount++;
        cmd_ins = 4'b0101;
        for (int i = 0; i < 30; i++) begin
            step();
            if (hb_ins == 4'b0000 && dead_busy) coast++;
            else break;
        end
        checkCount++; if (coast !== DEAD) $display("FAIL turn_right_coast got=%0d want=%0d", coast, DEAD); else passCount++;
        checkCount++; if (hb_ins !== 4'b0101) $display("FAIL turn_right got=%b want=0101", hb_ins); else passCount++;
        cmd_ins = 4'b0000;
        step();
        checkCount++; if (hb_ins !== 4'b0000) $display("FAIL turn_coast got=%b want=0000", hb_ins); else passCount++;
        cmd_ins = 4'b1010;
        step();
        checkCount++; if (hb_ins !== 4'b1010 || dead_busy !== 1'b0)
            $display("FAIL turn_left got hb=%b busy=%b want 1010/0", hb_ins, dead_busy); else passCount++;
    endtask

    task automatic test_invalid();
        cmd_ins = 4'b0011;
        step();
        checkCount++; if (hb_ins !== 4'b0000) $display("FAIL inv_coast got=%b want=0000", hb_ins); else passCount++;
        checkCount++; if (cmd_invalid !== 1'b1) $display("FAIL inv_pulse got=%b want=1", cmd_invalid); else passCount++;
        cmd_ins = 4'b0000;
        step();
        checkCount++; if (cmd_invalid !== 1'b0) $display("FAIL inv_pulse_end got=%b want=0", cmd_invalid); else passCount++;
    endtask

    task automatic test_pwm_duty();
        int guard = 0;
        int oldHigh = 0;
        int newHigh = 0;
        int zeroHigh = 0;
        cmd_ins = 4'b0110; duty = 6'd40;
        step();
        // Let duty 40 be latched, then move to the middle of a period.
        while ((mN % 128) != 1 && guard < 300) begin step(); guard++; end
        while ((mN % 128) != 64 && guard < 600) begin step(); guard++; end
        checkCount++; if ((mN % 128) != 64) $display("FAIL pwm_align timeout guard=%0d want phase 64", guard); else passCount++;
        duty = 6'd16;
        for (int i = 0; i < 64; i++) begin step(); oldHigh += int'(ena); end
        checkCount++; if (oldHigh !== 16) $display("FAIL pwm_old_duty high=%0d want=16", oldHigh); else passCount++;
        for (int i = 0; i < 128; i++) begin step(); newHigh += int'(ena); end
        checkCount++; if (newHigh !== 32) $display("FAIL pwm_duty16 high=%0d want=32", newHigh); else passCount++;
        duty = 6'd0;
        for (int i = 0; i < 128; i++) begin
            step();
            checkCount++; if (ena !== mEna) $display("FAIL pwm_trans cyc=%0d got=%b want=%b", i, ena, mEna); else passCount++;
        end
        for (int i = 0; i < 128; i++) begin step(); zeroHigh += int'(ena); end
        checkCount++; if (zeroHigh !== 0) $display("FAIL pwm_duty0 high=%0d want=0", zeroHigh); else passCount++;
    endtask

    task automatic test_reset_mid_dead();
        cmd_ins = 4'b1001;
        step(); step(); step();
        checkCount++; if (dead_busy !== 1'b1) $display("FAIL rst_dead_pre got=%b want=1", dead_busy); else passCount++;
        reset = 1'b1;
        step();
        checkCount++; if ({hb_ins, ena, enb, dead_busy, cmd_invalid} !== 8'b0)
            $display("FAIL rst_dead_outs got=%b want=00000000", {hb_ins, ena, enb, dead_busy, cmd_invalid}); else passCount++;
        reset = 1'b0; cmd_ins = 4'b0000;
        step();
        checkCount++; if (hb_ins !== 4'b0000 || dead_busy !== 1'b0)
            $display("FAIL rst_dead_no_pending got hb=%b busy=%b want 0000/0", hb_ins, dead_busy); else passCount++;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 7))
                    0: cmd_ins = 4'b0000;
                    1: cmd_ins = 4'b1111;
                    2: cmd_ins = 4'b0110;
                    3: cmd_ins = 4'b1001;
                    4: cmd_ins = 4'b0101;
                    5: cmd_ins = 4'b1010;
                    default: cmd_ins = 4'($urandom);
                endcase
                hold = int'($urandom_range(1, 15));
                if ($urandom_range(0, 3) == 0) duty = 6'($urandom);
            end
            hold--;
            step();
            checkCount++; if (hb_ins !== mApplied) $display("FAIL rnd_hb cyc=%0d got=%b want=%b", i, hb_ins, mApplied); else passCount++;
            checkCount++; if (applied_ins !== mApplied) $display("FAIL rnd_applied cyc=%0d got=%b want=%b", i, applied_ins, mApplied); else passCount++;
            checkCount++; if (ena !== mEna) $display("FAIL rnd_ena cyc=%0d got=%b want=%b", i, ena, mEna); else passCount++;
            checkCount++; if (enb !== mEna) $display("FAIL rnd_enb cyc=%0d got=%b want=%b", i, enb, mEna); else passCount++;
            checkCount++; if (dead_busy !== mBusy) $display("FAIL rnd_busy cyc=%0d got=%b want=%b", i, dead_busy, mBusy); else passCount++;
            checkCount++; if (cmd_invalid !== mInvalid) $display("FAIL rnd_invalid cyc=%0d got=%b want=%b", i, cmd_invalid, mInvalid); else passCount++;
        end
    endtask

    initial begin
        reset = 1'b1; cmd_ins = 4'b0000; duty = 6'd0;
        test_reset();
        test_forward();
        test_reversal();
        test_brake_abort();
        test_turns();
        test_invalid();
        test_pwm_duty();
        test_reset_mid_dead();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
